program_memory: RTL and testbench

- Writable, registered instruction store that replaces the fixed combinational program table feeding the CPU fetch stage.
- Word width and depth are parametrised.
- Clears itself to NOP after reset.
- Accepts a new program as a byte stream over a valid/ready loader port, assembling bytes into words, while the CPU fetch port is blocked.

---
 rtl/program_memory.sv | 179 +++++++++++++++++
 tb/tb_program_memory.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory.sv
// Writable registered instruction store with self-clear on reset and a byte-stream loader.
// Optional per-word even parity is enabled by defining PROGMEM_PARITY_EN.
module program_memory #(
    parameter int unsigned            ADDR_WIDTH  = 8,
    parameter int unsigned            INSTR_WIDTH = 32,
    parameter int unsigned            DEPTH       = 256,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   fetch_en,
    input  logic [ADDR_WIDTH-1:0]  fetch_addr,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    input  logic                   load_start,
    input  logic [ADDR_WIDTH-1:0]  load_base,
    input  logic [7:0]             load_byte,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic                   load_done,
    output logic                   busy,
    output logic [ADDR_WIDTH:0]    load_count,
    output logic                   load_overflow,
    output logic                   parity_error
);

    localparam int unsigned           BYTES     = INSTR_WIDTH / 8;
    localparam int unsigned           CNT_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES - 1);

    typedef enum logic [1:0] {StClear, StRun, StLoad} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    // One bit wider than a fetch address so the pointer can step past DEPTH-1 and be dropped.
    logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic [INSTR_WIDTH-1:0]  asm_q, asm_d;
    logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
    logic                    valid_q, valid_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    perr_q, perr_d;

    logic [INSTR_WIDTH-1:0]  mem [DEPTH];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [INSTR_WIDTH-1:0]  mem_wdata;
    logic [INSTR_WIDTH-1:0]  word_next;
    logic                    fetch_hit;
    logic                    fetch_bad;

    assign fetch_hit = ({1'b0, fetch_addr} < DEPTH_W);

`ifdef PROGMEM_PARITY_EN
    logic mem_par [DEPTH];
    assign fetch_bad = fetch_hit && (mem_par[fetch_addr] != ^mem[fetch_addr]);
`else
    assign fetch_bad = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        instr_d    = instr_q;
        valid_d    = 1'b0;
        count_d    = count_q;
        ovf_d      = ovf_q;
        perr_d     = perr_q;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = NOP_WORD;
        word_next  = (asm_q << 8) | INSTR_WIDTH'(load_byte);

        if (load_start && state_q != StClear) begin
            // Restart wins over load_done and over any fetch in the same cycle.
            state_d    = StLoad;
            wr_ptr_d   = {1'b0, load_base};
            byte_cnt_d = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
            perr_d     = 1'b0;
            instr_d    = NOP_WORD;
        end else begin
            unique case (state_q)
                StClear: begin
                    mem_we    = 1'b1;
                    mem_waddr = clr_ptr_q;
                    clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
                    if (clr_ptr_q == CLR_LAST) begin
                        state_d   = StRun;
                        clr_ptr_d = '0;
                    end
                end
                StRun: begin
                    if (fetch_en) begin
                        valid_d = 1'b1;
                        instr_d = fetch_hit ? mem[fetch_addr] : NOP_WORD;
                        if (fetch_bad) perr_d = 1'b1;
                    end
                end
                StLoad: begin
                    instr_d = NOP_WORD;
                    if (load_valid) begin
                        asm_d = word_next;
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d = '0;
                            if (wr_ptr_q < DEPTH_W) begin
                                mem_we    = 1'b1;
                                mem_waddr = wr_ptr_q[ADDR_WIDTH-1:0];
                                mem_wdata = word_next;
                                count_d   = count_q + (ADDR_WIDTH + 1)'(1);
                            end else begin
                                ovf_d = 1'b1;
                            end
                            if (wr_ptr_q != '1) wr_ptr_d = wr_ptr_q + (ADDR_WIDTH + 1)'(1);
                        end else begin
                            byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        end
                    end
                    if (load_done) begin
                        state_d    = StRun;
                        byte_cnt_d = '0;
                    end
                end
                default: state_d = StClear;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StClear;
            clr_ptr_q  <= '0;
            wr_ptr_q   <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            instr_q    <= NOP_WORD;
            valid_q    <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
`ifdef PROGMEM_PARITY_EN
            mem_par[mem_waddr] <= ^mem_wdata;
`endif
        end
    end

    assign instruction   = instr_q;
    assign instr_valid   = valid_q;
    assign load_ready    = (state_q == StLoad);
    assign busy          = (state_q != StRun);
    assign load_count    = count_q;
    assign load_overflow = ovf_q;
    assign parity_error  = perr_q;

endmodule

// File: tb/tb_program_memory.sv
// Randomised bench for program_memory against a queue/array reference model of the store.
module tb_program_memory;

    localparam int AW    = 8;
    localparam int IW    = 32;
    localparam int DEPTH = 256;

    logic          clock = 1'b0;
    logic          reset;
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;
    logic [IW-1:0] instruction;
    logic          instr_valid;
    logic          load_start;
    logic [AW-1:0] load_base;
    logic [7:0]    load_byte;
    logic          load_valid;
    logic          load_ready;
    logic          load_done;
    logic          busy;
    logic [AW:0]   load_count;
    logic          load_overflow;
    logic          parity_error;

    always #5 clock = ~clock;

    program_memory #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .DEPTH      (DEPTH),
        .NOP_WORD   ('0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .fetch_en     (fetch_en),
        .fetch_addr   (fetch_addr),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .load_start   (load_start),
        .load_base    (load_base),
        .load_byte    (load_byte),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_done    (load_done),
        .busy         (busy),
        .load_count   (load_count),
        .load_overflow(load_overflow),
        .parity_error (parity_error)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the store as a plain array, the loader as a byte queue.
    bit          model_on = 1'b0;
    int          clr_left;
    bit          loading;
    int          ptr;
    logic [7:0]  part[$];
    logic [31:0] mmem[DEPTH];
    bit          par_bad[DEPTH];
    logic [31:0] e_instr;
    bit          e_valid;
    int          e_count;
    bit          e_ovf;
    bit          e_perr;

    task automatic model_step();
        if (reset) begin
            model_on = 1'b1;
            clr_left = DEPTH;
            loading  = 1'b0;
            e_instr  = '0;
            e_valid  = 1'b0;
            e_count  = 0;
            e_ovf    = 1'b0;
            e_perr   = 1'b0;
            part.delete();
        end else if (clr_left > 0) begin
            mmem[DEPTH - clr_left]    = '0;
            par_bad[DEPTH - clr_left] = 1'b0;
            clr_left--;
            e_valid = 1'b0;
        end else if (load_start) begin
            loading = 1'b1;
            ptr     = int'(load_base);
            part.delete();
            e_count = 0;
            e_ovf   = 1'b0;
            e_perr  = 1'b0;
            e_valid = 1'b0;
            e_instr = '0;
        end else if (loading) begin
            if (load_valid) begin
                part.push_back(load_byte);
                if (part.size() == IW / 8) begin
                    if (ptr < DEPTH) begin
                        mmem[ptr]    = {part[0], part[1], part[2], part[3]};
                        par_bad[ptr] = 1'b0;
                        e_count++;
                    end else begin
                        e_ovf = 1'b1;
                    end
                    ptr = (ptr < 2 ** (AW + 1) - 1) ? ptr + 1 : ptr;
                    part.delete();
                end
            end
            if (load_done) begin
                loading = 1'b0;
                part.delete();
            end
            e_valid = 1'b0;
        end else if (fetch_en) begin
            e_valid = 1'b1;
            e_instr = (int'(fetch_addr) < DEPTH) ? mmem[fetch_addr] : '0;
            if (int'(fetch_addr) < DEPTH && par_bad[fetch_addr]) e_perr = 1'b1;
        end else begin
            e_valid = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
            #1;
            if (model_on) begin
                chk("busy", busy, (clr_left > 0) || loading);
                chk("load_ready", load_ready, loading);
                chk("instr_valid", instr_valid, e_valid);
                chk("instruction", instruction, e_instr);
                chk("load_count", load_count, e_count);
                chk("load_overflow", load_overflow, e_ovf);
                chk("parity_error", parity_error, e_perr);
            end
        end
    end

    task automatic fetch(input int a);
        fetch_en   = 1'b1;
        fetch_addr = AW'(a);
        @(negedge clock);
        fetch_en = 1'b0;
    endtask

    task automatic start(input int base);
        load_start = 1'b1;
        load_base  = AW'(base);
        @(negedge clock);
        load_start = 1'b0;
    endtask

    task automatic put(input logic [7:0] b, input bit done);
        load_valid = 1'b1;
        load_byte  = b;
        load_done  = done;
        @(negedge clock);
        load_valid = 1'b0;
        load_done  = 1'b0;
    endtask

    task automatic finish_load();
        load_done = 1'b1;
        @(negedge clock);
        load_done = 1'b0;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (busy && n < 400) begin
            n++;
            @(negedge clock);
        end
        chk("clear_finished", busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset      = 1'b1;
        fetch_en   = 1'b0;
        fetch_addr = '0;
        load_start = 1'b0;
        load_base  = '0;
        load_byte  = '0;
        load_valid = 1'b0;
        load_done  = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_busy", busy, 1'b1);
        chk("reset_instruction", instruction, 32'h0);
        reset = 1'b0;
        wait_run(n);
        chk("clear_length", n, 256);

        fetch(5);
        chk("fetch5_data", instruction, 32'h0);
        chk("fetch5_valid", instr_valid, 1'b1);

        start(3);
        foreach (n_bytes_a[i]) put(n_bytes_a[i], 1'b0);
        finish_load();
        chk("load3_count", load_count, 2);
        chk("model_mem3", mmem[3], 32'hA1B2C3D4);
        fetch(3);
        chk("fetch3", instruction, 32'hA1B2C3D4);
        fetch(4);
        chk("fetch4", instruction, 32'hE5F60718);

        start(255);
        foreach (n_bytes_b[i]) put(n_bytes_b[i], 1'b0);
        finish_load();
        chk("edge_count", load_count, 1);
        chk("edge_overflow", load_overflow, 1'b1);
        fetch(0);
        chk("fetch0_after_edge", instruction, 32'h0);
        fetch(255);
        chk("fetch255", instruction, 32'h11223344);

        start(20);
        for (int i = 1; i <= 6; i++) put(8'(i), 1'b0);
        finish_load();
        chk("partial_count", load_count, 1);
        fetch(20);
        chk("fetch20", instruction, 32'h01020304);
        fetch(21);
        chk("fetch21_untouched", instruction, 32'h0);

        start(30);
        put(8'h9A, 1'b0);
        put(8'hBC, 1'b0);
        put(8'hDE, 1'b0);
        put(8'hF0, 1'b1);
        chk("done_with_byte_busy", busy, 1'b0);
        chk("done_with_byte_count", load_count, 1);
        fetch(30);
        chk("fetch30", instruction, 32'h9ABCDEF0);

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 8)) begin
                    fetch_en   = ($urandom_range(0, 3) != 0);
                    fetch_addr = AW'($urandom);
                    @(negedge clock);
                end
                fetch_en = 1'b0;
            end else begin
                start(($urandom_range(0, 3) == 0) ? $urandom_range(250, 255) : $urandom_range(0, 255));
                repeat ($urandom_range(0, 14)) begin
                    load_valid = ($urandom_range(0, 3) != 0);
                    load_byte  = 8'($urandom);
                    fetch_en   = $urandom_range(0, 1);
                    fetch_addr = AW'($urandom);
                    load_start = ($urandom_range(0, 15) == 0);
                    load_base  = AW'($urandom);
                    @(negedge clock);
                end
                load_start = 1'b0;
                fetch_en   = 1'b0;
                load_valid = $urandom_range(0, 1);
                load_byte  = 8'($urandom);
                finish_load();
                load_valid = 1'b0;
            end
        end

        start(50);
        for (int i = 0; i < 8; i++) put(8'(8'h40 + i), 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        wait_run(n);
        chk("midload_reset_clear_length", n, 256);
        chk("midload_reset_overflow", load_overflow, 1'b0);
        for (int a = 0; a < DEPTH; a++) begin
            fetch_en   = 1'b1;
            fetch_addr = AW'(a);
            @(negedge clock);
        end
        fetch_en = 1'b0;
        fetch(50);
        chk("fetch50_after_reset", instruction, 32'h0);

`ifdef PROGMEM_PARITY_EN
        dut.mem_par[10] = ~dut.mem_par[10];
        par_bad[10]     = 1'b1;
        fetch(10);
        chk("parity_flag", parity_error, 1'b1);
        chk("parity_valid", instr_valid, 1'b1);
        start(0);
        chk("parity_cleared", parity_error, 1'b0);
        finish_load();
`endif

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    logic [7:0] n_bytes_a[8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    logic [7:0] n_bytes_b[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

endmodule
